multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM sequencing the RV32I-subset datapath (instruction register, register file, ALU, PC, unified memory port) around the field decoder. It consumes the decoded `op`/`fun3`/`fun7` fields and per-cycle status (`mem_ready`, `br_taken`). It produces every write-enable, mux select and memory request for one instruction at a time. Supported classes: R (0110011), I-ALU (0010011), Load (0000011), Store (0100011), Branch (1100011); any other opcode traps.

## Interface
- `CNT_W`, default 32: width of performance counters; used only when `CTRL_PERF_CNT_EN` is defined.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `op`  in  7: opcode from decoder (`instr[6:0]`).
- `fun3`  in  3: funct3 from decoder.
- `fun7`  in  7: funct7 from decoder; only bit 5 is used.
- `mem_ready`  in  1: memory completes the current request this cycle.
- `br_taken`  in  1: ALU compare result for the current branch, valid in EXEC.
- `mem_req`  out  1: memory request; held until `mem_ready`.
- `mem_we`  out  1: request is a write (store).
- `ir_we`  out  1: load the instruction register.
- `pc_we`  out  1: write the PC.
- `pc_sel`  out  1: PC source; 0 = PC+4, 1 = branch target (old PC + imm).
- `reg_we`  out  1: register-file write.
- `wb_sel`  out  1: write-back source; 0 = ALU, 1 = memory data.
- `alu_src`  out  1: ALU operand B; 0 = rs2, 1 = imm.
- `alu_op`  out  4: ALU operation.
- `state`  out  3: current state (debug).
- `trap`  out  1: illegal opcode seen; sticky.
- `cycle_cnt`, `instret_cnt`  out  CNT_W: present only with `CTRL_PERF_CNT_EN`.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Only the state register (plus counters) is sequential; all strobes are combinational from state, `op`, `fun3`, `fun7` and handshake inputs.
- **FETCH:** `mem_req`=1, `mem_we`=0. While `mem_ready`=0, stay in FETCH. When `mem_ready`=1, `ir_we`=1, `pc_we`=1, `pc_sel`=0, and go to DECODE.
- **DECODE:** no strobes (register file is read). Legal `op` goes to EXEC; any other `op` goes to TRAP.
- **EXEC:**
  - R: `alu_src`=0, `alu_op`={fun7[5],fun3}; go to WB.
  - I-ALU: `alu_src`=1, `alu_op`={(fun3==101)?fun7[5]:0, fun3}; go to WB.
  - Load/Store: `alu_src`=1, `alu_op`=0000; go to MEM.
  - Branch: `alu_src`=0, `alu_op`={1,fun3}. If `br_taken`=1, assert `pc_we`=1 and `pc_sel`=1. Return to FETCH.
- **MEM:** `mem_req`=1, `mem_we`=(op==Store). While `mem_ready`=0, stay in MEM. When `mem_ready`=1: a Load goes to WB, a Store goes to FETCH.
- **WB:** `reg_we`=1, `wb_sel`=(op==Load); go to FETCH.
- **TRAP:** all strobes 0, `trap`=1. TRAP is absorbing; only `rst` leaves it.
- `alu_op`, `alu_src`, `wb_sel`, `pc_sel` are 0 in every state or case not listed above.

## Timing
- Reset: a synchronous `rst` in any state puts the FSM in FETCH on the next edge.
  - During the reset cycle all outputs are 0, including `mem_req`; the outstanding request is abandoned.
  - Counters clear to 0.
  - After the first post-reset edge, `mem_req`=1.
- Cycles per instruction with zero wait states (`mem_ready` high on the first request cycle):
  - R / I-ALU: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3, taken or not taken.
- Each wait cycle adds one cycle. There is no timeout; `mem_req` stays high indefinitely.
- `ir_we` and FETCH `pc_we` pulse for exactly one cycle, coincident with `mem_ready`.
- `mem_ready` is ignored outside FETCH and MEM.
- `br_taken` is sampled only in EXEC for a branch.
- `op`/`fun*` are assumed stable from DECODE to the end of the instruction, because IR is written only in FETCH.

## Configuration
- `CTRL_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every non-reset cycle, including TRAP.
  - `instret_cnt` increments on the last cycle of each completed instruction: WB exit, Store MEM exit with `mem_ready`, or Branch EXEC.
  - Both wrap modulo 2^CNT_W.
- Undefined: the two ports and all counter logic are absent; behaviour is otherwise identical.

## Test plan
- Reset then R-type `add` (op=0110011, fun3=000, fun7=0000000), `mem_ready` tied 1:
  - `state` sequence 0,1,2,4,0.
  - `alu_op`=0000 in EXEC; `reg_we`=1 only in WB; `pc_we` only in FETCH.
- `srai` (op=0010011, fun3=101, fun7=0100000): `alu_op`=1101, `alu_src`=1 in EXEC. Load `lw` with `mem_ready` low for 3 MEM cycles: MEM lasts 4 cycles, then WB with `wb_sel`=1, 8 cycles total.
- Store `sw`: MEM has `mem_we`=1 and no `reg_we` anywhere. Branch `beq` with `br_taken`=1: EXEC has `pc_we`=1, `pc_sel`=1; with `br_taken`=0: `pc_we`=0. Both return to FETCH after 3 cycles.
- Illegal op=1111111: DECODE goes to TRAP, `trap`=1, `mem_req` stays 0 for 20 cycles; `rst` returns `state`=0 and `trap`=0.
- `rst` asserted in MEM during a load wait: next cycle `state`=0, all strobes 0, no `reg_we` ever issued for the aborted load.
- With `CTRL_PERF_CNT_EN`, CNT_W=4: 5 zero-wait R-type instructions give `instret_cnt`=5 and `cycle_cnt`=20 mod 16 = 4.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM: fetch/decode/exec/mem/wb/trap.
// Optional perf counters enabled by defining CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] fun3,
  input  logic [6:0] fun7,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       alu_src,
  output logic [3:0] alu_op,
  output logic [2:0] state,
  output logic       trap
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t r_state;
  state_t w_next;

  logic w_is_r;
  logic w_is_i;
  logic w_is_ld;
  logic w_is_st;
  logic w_is_br;
  logic w_legal;

  assign w_is_r  = (op == OP_R);
  assign w_is_i  = (op == OP_I);
  assign w_is_ld = (op == OP_LD);
  assign w_is_st = (op == OP_ST);
  assign w_is_br = (op == OP_BR);
  assign w_legal = w_is_r | w_is_i | w_is_ld
                 | w_is_st | w_is_br;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 1'b0;
    reg_we  = 1'b0;
    wb_sel  = 1'b0;
    alu_src = 1'b0;
    alu_op  = 4'b0000;
    trap    = 1'b0;
    state   = 3'd0;
    // Reset cycle drops every output, abandoning any open request.
    if (!rst) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we  = 1'b1;
            pc_we  = 1'b1;
            w_next = S_DECODE;
          end
        end
        S_DECODE: begin
          w_next = w_legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          unique case (1'b1)
            w_is_r: begin
              alu_op = {fun7[5], fun3};
              w_next = S_WB;
            end
            w_is_i: begin
              alu_src = 1'b1;
              alu_op  = {(fun3 == 3'b101) & fun7[5], fun3};
              w_next  = S_WB;
            end
            w_is_ld, w_is_st: begin
              alu_src = 1'b1;
              w_next  = S_MEM;
            end
            w_is_br: begin
              alu_op = {1'b1, fun3};
              pc_we  = br_taken;
              pc_sel = br_taken;
              w_next = S_FETCH;
            end
            default: w_next = S_TRAP;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = w_is_st;
          if (mem_ready)
            w_next = w_is_ld ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_we = 1'b1;
          wb_sel = w_is_ld;
          w_next = S_FETCH;
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: w_next = S_TRAP;
      endcase
    end
  end

  logic w_unused;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_ret;
  logic             w_retire;

  // Last cycle of an instruction: WB, store completion, any branch.
  assign w_retire = (r_state == S_WB)
                  | ((r_state == S_MEM) & w_is_st & mem_ready)
                  | ((r_state == S_EXEC) & w_is_br);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else begin
      r_cyc <= r_cyc + CNT_W'(1);
      if (w_retire) r_ret <= r_ret + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cyc;
  assign instret_cnt = r_ret;
  assign w_unused    = ^{fun7[6], fun7[4:0]};
`else
  assign w_unused    = ^{fun7[6], fun7[4:0], CNT_W[0]};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/strobe checks.
// Counter checks run when CTRL_PERF_CNT_EN is defined.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] fun3;
  logic [6:0] fun7;
  logic       mem_ready;
  logic       br_taken;
  logic       mem_req;
  logic       mem_we;
  logic       ir_we;
  logic       pc_we;
  logic       pc_sel;
  logic       reg_we;
  logic       wb_sel;
  logic       alu_src;
  logic [3:0] alu_op;
  logic [2:0] state;
  logic       trap;
`ifdef CTRL_PERF_CNT_EN
  logic [3:0] cycle_cnt;
  logic [3:0] instret_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef CTRL_PERF_CNT_EN
  multicycle_ctrl #(.CNT_W(4)) dut (
`else
  multicycle_ctrl dut (
`endif
    .clk(clk), .rst(rst), .op(op), .fun3(fun3),
    .fun7(fun7), .mem_ready(mem_ready),
    .br_taken(br_taken), .mem_req(mem_req),
    .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .reg_we(reg_we),
    .wb_sel(wb_sel), .alu_src(alu_src),
    .alu_op(alu_op), .state(state), .trap(trap)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  // {mem_req,mem_we,ir_we,pc_we,pc_sel,reg_we,wb_sel,alu_src,trap,alu_op}
  logic [12:0] obs;
  assign obs = {mem_req, mem_we, ir_we, pc_we, pc_sel,
                reg_we, wb_sel, alu_src, trap, alu_op};

  localparam logic [12:0] Z      = 13'b0_0_0_0_0_0_0_0_0_0000;
  localparam logic [12:0] F_RDY  = 13'b1_0_1_1_0_0_0_0_0_0000;
  localparam logic [12:0] F_WAIT = 13'b1_0_0_0_0_0_0_0_0_0000;
  localparam logic [12:0] WB_ALU = 13'b0_0_0_0_0_1_0_0_0_0000;
  localparam logic [12:0] WB_MEM = 13'b0_0_0_0_0_1_1_0_0_0000;
  localparam logic [12:0] EX_IMM = 13'b0_0_0_0_0_0_0_1_0_0000;
  localparam logic [12:0] EX_SRA = 13'b0_0_0_0_0_0_0_1_0_1101;
  localparam logic [12:0] EX_SUB = 13'b0_0_0_0_0_0_0_0_0_1000;
  localparam logic [12:0] EX_BT  = 13'b0_0_0_1_1_0_0_0_0_1000;
  localparam logic [12:0] EX_BN  = 13'b0_0_0_0_0_0_0_0_0_1001;
  localparam logic [12:0] MEM_LD = 13'b1_0_0_0_0_0_0_0_0_0000;
  localparam logic [12:0] MEM_ST = 13'b1_1_0_0_0_0_0_0_0_0000;
  localparam logic [12:0] TRP    = 13'b0_0_0_0_0_0_0_0_1_0000;

  task automatic chk(input string tag, input logic [2:0] es,
                     input logic [12:0] ev);
    n_vec++;
    assert (state === es && obs === ev) else begin
      n_err++;
      $error("FAIL %s: state=%0d strobes=%b, required state=%0d strobes=%b",
             tag, state, obs, es, ev);
    end
  endtask

  // Settle, check, then move to just after the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] es,
                     input logic [12:0] ev);
    #1;
    chk(tag, es, ev);
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7);
    op   = o;
    fun3 = f3;
    fun7 = f7;
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    br_taken  = 1'b0;
    set_op(7'b0110011, 3'b000, 7'b0000000);
    cyc("rst_out", 3'd0, Z);
    rst = 1'b0;

    // add
    cyc("add_f", 3'd0, F_RDY);
    cyc("add_d", 3'd1, Z);
    mem_ready = 1'b0;
    cyc("add_e", 3'd2, Z);
    cyc("add_wb", 3'd4, WB_ALU);

    // sub, with one fetch wait state
    cyc("sub_fw", 3'd0, F_WAIT);
    mem_ready = 1'b1;
    cyc("sub_f", 3'd0, F_RDY);
    set_op(7'b0110011, 3'b000, 7'b0100000);
    cyc("sub_d", 3'd1, Z);
    cyc("sub_e", 3'd2, EX_SUB);
    cyc("sub_wb", 3'd4, WB_ALU);

    // srai
    cyc("srai_f", 3'd0, F_RDY);
    set_op(7'b0010011, 3'b101, 7'b0100000);
    cyc("srai_d", 3'd1, Z);
    cyc("srai_e", 3'd2, EX_SRA);
    cyc("srai_wb", 3'd4, WB_ALU);

    // addi with imm[10] set: fun7[5] must not reach alu_op
    cyc("addi_f", 3'd0, F_RDY);
    set_op(7'b0010011, 3'b000, 7'b0100000);
    cyc("addi_d", 3'd1, Z);
    cyc("addi_e", 3'd2, EX_IMM);
    cyc("addi_wb", 3'd4, WB_ALU);

    // lw with 3 MEM wait cycles: 8 cycles total
    cyc("lw_f", 3'd0, F_RDY);
    set_op(7'b0000011, 3'b010, 7'b0000000);
    cyc("lw_d", 3'd1, Z);
    cyc("lw_e", 3'd2, EX_IMM);
    mem_ready = 1'b0;
    cyc("lw_m0", 3'd3, MEM_LD);
    cyc("lw_m1", 3'd3, MEM_LD);
    cyc("lw_m2", 3'd3, MEM_LD);
    mem_ready = 1'b1;
    cyc("lw_m3", 3'd3, MEM_LD);
    cyc("lw_wb", 3'd4, WB_MEM);

    // sw
    cyc("sw_f", 3'd0, F_RDY);
    set_op(7'b0100011, 3'b010, 7'b0000000);
    cyc("sw_d", 3'd1, Z);
    cyc("sw_e", 3'd2, EX_IMM);
    cyc("sw_m", 3'd3, MEM_ST);

    // beq taken
    cyc("beq_f", 3'd0, F_RDY);
    set_op(7'b1100011, 3'b000, 7'b0000000);
    cyc("beq_d", 3'd1, Z);
    br_taken = 1'b1;
    cyc("beq_e", 3'd2, EX_BT);
    br_taken = 1'b0;

    // bne not taken
    cyc("bne_f", 3'd0, F_RDY);
    set_op(7'b1100011, 3'b001, 7'b0000000);
    cyc("bne_d", 3'd1, Z);
    cyc("bne_e", 3'd2, EX_BN);

    // illegal opcode traps and holds
    cyc("ill_f", 3'd0, F_RDY);
    set_op(7'b1111111, 3'b000, 7'b0000000);
    cyc("ill_d", 3'd1, Z);
    for (int i = 0; i < 20; i++) cyc("trap_hold", 3'd7, TRP);
    rst = 1'b1;
    cyc("trap_rst", 3'd0, Z);
    rst = 1'b0;
    set_op(7'b0000011, 3'b010, 7'b0000000);
    cyc("post_trap_f", 3'd0, F_RDY);

    // reset during a load wait
    cyc("ab_d", 3'd1, Z);
    cyc("ab_e", 3'd2, EX_IMM);
    mem_ready = 1'b0;
    cyc("ab_m0", 3'd3, MEM_LD);
    rst = 1'b1;
    cyc("ab_rst", 3'd0, Z);
    rst = 1'b0;
    cyc("ab_fw", 3'd0, F_WAIT);
    mem_ready = 1'b1;

`ifdef CTRL_PERF_CNT_EN
    rst = 1'b1;
    cyc("cnt_rst", 3'd0, Z);
    rst = 1'b0;
    n_vec++;
    assert (cycle_cnt === 4'd0 && instret_cnt === 4'd0) else begin
      n_err++;
      $error("FAIL cnt_clr: cyc=%0d ret=%0d, required 0/0",
             cycle_cnt, instret_cnt);
    end
    set_op(7'b0110011, 3'b000, 7'b0000000);
    for (int i = 0; i < 5; i++) begin
      cyc("cnt_f", 3'd0, F_RDY);
      cyc("cnt_d", 3'd1, Z);
      cyc("cnt_e", 3'd2, Z);
      cyc("cnt_wb", 3'd4, WB_ALU);
    end
    n_vec++;
    assert (cycle_cnt === 4'd4 && instret_cnt === 4'd5) else begin
      n_err++;
      $error("FAIL cnt_5r: cyc=%0d ret=%0d, required 4/5",
             cycle_cnt, instret_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
